// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: ID-stage operands in, registered EX-stage operands out.
// o_valid = 1 marks a real instruction in EX; o_valid = 0 marks a bubble.
interface id_ex_stage_if #(
  parameter int NB_CONTROL = 18,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_COUNT   = 16
);
  logic                  i_enable;
  logic                  i_flush;
  logic [NB_CONTROL-1:0] i_control;
  logic [NB_DATA-1:0]    i_pc;
  logic [NB_DATA-1:0]    i_rs_data;
  logic [NB_DATA-1:0]    i_rt_data;
  logic [NB_DATA-1:0]    i_imm_ext;
  logic [NB_REG-1:0]     i_rs_addr;
  logic [NB_REG-1:0]     i_rt_addr;
  logic [NB_REG-1:0]     i_rd_addr;
  logic [NB_REG-1:0]     i_shamt;
  logic                  o_stall;
  logic [NB_CONTROL-1:0] o_control;
  logic [NB_DATA-1:0]    o_pc;
  logic [NB_DATA-1:0]    o_rs_data;
  logic [NB_DATA-1:0]    o_rt_data;
  logic [NB_DATA-1:0]    o_imm_ext;
  logic [NB_REG-1:0]     o_rs_addr;
  logic [NB_REG-1:0]     o_rt_addr;
  logic [NB_REG-1:0]     o_rd_addr;
  logic [NB_REG-1:0]     o_shamt;
  logic                  o_valid;
  logic [NB_COUNT-1:0]   o_bubble_count;

  modport master (
    output i_enable, i_flush, i_control, i_pc, i_rs_data, i_rt_data, i_imm_ext,
           i_rs_addr, i_rt_addr, i_rd_addr, i_shamt,
    input  o_stall, o_control, o_pc, o_rs_data, o_rt_data, o_imm_ext,
           o_rs_addr, o_rt_addr, o_rd_addr, o_shamt, o_valid, o_bubble_count
  );

  modport slave (
    input  i_enable, i_flush, i_control, i_pc, i_rs_data, i_rt_data, i_imm_ext,
           i_rs_addr, i_rt_addr, i_rd_addr, i_shamt,
    output o_stall, o_control, o_pc, o_rs_data, o_rt_data, o_imm_ext,
           o_rs_addr, o_rt_addr, o_rd_addr, o_shamt, o_valid, o_bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int NB_CONTROL = 18,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_COUNT   = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  id_ex_stage_if.slave  bus
);
  localparam int MEM_READ_BIT = 15;

  logic [NB_CONTROL-1:0] control_q, control_d;
  logic [NB_DATA-1:0]    pc_q, pc_d, rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]    rt_data_q, rt_data_d, imm_ext_q, imm_ext_d;
  logic [NB_REG-1:0]     rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
  logic [NB_REG-1:0]     rd_addr_q, rd_addr_d, shamt_q, shamt_d;
  logic                  valid_q, valid_d;
  logic [NB_COUNT-1:0]   count_q, count_d;
  logic                  hazard;
  logic                  bubble;

  // Load in EX whose destination is read by ID; not qualified by opcode.
  assign hazard = valid_q & control_q[MEM_READ_BIT] & (rt_addr_q != '0) &
                  ((rt_addr_q == bus.i_rs_addr) | (rt_addr_q == bus.i_rt_addr));
  assign bubble = bus.i_flush | hazard;

  assign bus.o_stall = hazard & bus.i_enable & ~bus.i_flush;

  always_comb begin
    control_d = control_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_ext_d = imm_ext_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    shamt_d   = shamt_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (bus.i_enable) begin
      pc_d      = bus.i_pc;
      rs_data_d = bus.i_rs_data;
      rt_data_d = bus.i_rt_data;
      imm_ext_d = bus.i_imm_ext;
      rs_addr_d = bus.i_rs_addr;
      rt_addr_d = bus.i_rt_addr;
      rd_addr_d = bus.i_rd_addr;
      shamt_d   = bus.i_shamt;
      if (bubble) begin
        control_d = '0;
        valid_d   = 1'b0;
        if (count_q != '1) count_d = count_q + NB_COUNT'(1);
      end else begin
        control_d = bus.i_control;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      control_q <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_ext_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      shamt_q   <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      control_q <= control_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_ext_q <= imm_ext_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      shamt_q   <= shamt_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign bus.o_control      = control_q;
  assign bus.o_pc           = pc_q;
  assign bus.o_rs_data      = rs_data_q;
  assign bus.o_rt_data      = rt_data_q;
  assign bus.o_imm_ext      = imm_ext_q;
  assign bus.o_rs_addr      = rs_addr_q;
  assign bus.o_rt_addr      = rt_addr_q;
  assign bus.o_rd_addr      = rd_addr_q;
  assign bus.o_shamt        = shamt_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_bubble_count = count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table with a scoreboard queue, plus reset,
// reset-mid-stall and counter-saturation sequences.
module tb_id_ex_stage;
  localparam int W_DATA = 4*32 + 4*5;
  localparam int W      = 1 + 18 + 16 + W_DATA;
  localparam logic [17:0] LOAD = 18'h08100;
  localparam logic [17:0] ALU  = 18'h00100;

  typedef struct {
    logic        en;
    logic        fl;
    logic [17:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        exp_stall;
    logic        exp_valid;
    logic [17:0] exp_ctrl;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W_DATA-1:0] exp_data = '0;
  vec_t vecs[14];

  id_ex_stage_if #(.NB_CONTROL(18), .NB_DATA(32), .NB_REG(5), .NB_COUNT(16)) bus ();

  id_ex_stage #(.NB_CONTROL(18), .NB_DATA(32), .NB_REG(5), .NB_COUNT(16)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] dut_out();
    return {bus.o_valid, bus.o_control, bus.o_bubble_count,
            bus.o_pc, bus.o_rs_data, bus.o_rt_data, bus.o_imm_ext,
            bus.o_rs_addr, bus.o_rt_addr, bus.o_rd_addr, bus.o_shamt};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_random_operands();
    bus.i_pc      = $urandom;
    bus.i_rs_data = $urandom;
    bus.i_rt_data = $urandom;
    bus.i_imm_ext = $urandom;
    bus.i_rd_addr = 5'($urandom_range(0, 31));
    bus.i_shamt   = 5'($urandom_range(0, 31));
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    bus.i_enable  = v.en;
    bus.i_flush   = v.fl;
    bus.i_control = v.ctrl;
    bus.i_rs_addr = v.rs;
    bus.i_rt_addr = v.rt;
    drive_random_operands();
    #1;
    check($sformatf("stall[%0d]", idx), W'(bus.o_stall), W'(v.exp_stall));
    if (v.en)
      exp_data = {bus.i_pc, bus.i_rs_data, bus.i_rt_data, bus.i_imm_ext,
                  bus.i_rs_addr, bus.i_rt_addr, bus.i_rd_addr, bus.i_shamt};
    exp_q.push_back({v.exp_valid, v.exp_ctrl, v.exp_cnt, exp_data});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL regs[%0d]: act=empty_queue req=entry", idx);
    end else begin
      check($sformatf("regs[%0d]", idx), dut_out(), exp_q.pop_front());
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_enable  = 1'b1;
    bus.i_flush   = 1'($urandom_range(0, 1));
    bus.i_control = 18'($urandom);
    bus.i_rs_addr = 5'($urandom_range(0, 31));
    bus.i_rt_addr = 5'($urandom_range(0, 31));
    drive_random_operands();
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_regs", dut_out(), '0);
    check("reset_stall", W'(bus.o_stall), '0);
    exp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // exp: stall, valid, ctrl, count after the edge
    vecs[0]  = '{1'b1, 1'b0, LOAD, 5'd1, 5'd5, 1'b0, 1'b1, LOAD, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, ALU,  5'd5, 5'd2, 1'b1, 1'b0, 18'd0, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, ALU,  5'd5, 5'd2, 1'b0, 1'b1, ALU,  16'd1};
    vecs[3]  = '{1'b1, 1'b0, LOAD, 5'd3, 5'd0, 1'b0, 1'b1, LOAD, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, ALU,  5'd0, 5'd0, 1'b0, 1'b1, ALU,  16'd1};
    vecs[5]  = '{1'b1, 1'b0, LOAD, 5'd4, 5'd7, 1'b0, 1'b1, LOAD, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, ALU,  5'd1, 5'd7, 1'b0, 1'b0, 18'd0, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, LOAD, 5'd2, 5'd9, 1'b0, 1'b1, LOAD, 16'd2};
    vecs[8]  = '{1'b0, 1'b0, ALU,  5'd9, 5'd3, 1'b0, 1'b1, LOAD, 16'd2};
    vecs[9]  = '{1'b0, 1'b1, 18'd0, 5'd3, 5'd9, 1'b0, 1'b1, LOAD, 16'd2};
    vecs[10] = '{1'b0, 1'b0, LOAD, 5'd9, 5'd9, 1'b0, 1'b1, LOAD, 16'd2};
    vecs[11] = '{1'b1, 1'b0, ALU,  5'd9, 5'd3, 1'b1, 1'b0, 18'd0, 16'd3};
    vecs[12] = '{1'b1, 1'b0, ALU,  5'd9, 5'd3, 1'b0, 1'b1, ALU,  16'd3};
    vecs[13] = '{1'b1, 1'b1, LOAD, 5'd1, 5'd2, 1'b0, 1'b0, 18'd0, 16'd4};

    bus.i_enable = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_control = '0;
    bus.i_rs_addr = '0;
    bus.i_rt_addr = '0;
    drive_random_operands();

    do_reset(2);

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);

    // Reset arriving while a stall is asserted
    @(negedge clk);
    bus.i_enable = 1'b1; bus.i_flush = 1'b0;
    bus.i_control = LOAD; bus.i_rs_addr = 5'd1; bus.i_rt_addr = 5'd6;
    @(negedge clk);
    bus.i_control = ALU; bus.i_rs_addr = 5'd6; bus.i_rt_addr = 5'd1;
    rst_n = 1'b0;
    #1;
    check("pre_reset_stall", W'(bus.o_stall), W'(1'b1));
    @(posedge clk);
    #1;
    check("post_reset_regs", dut_out(), '0);
    check("post_reset_stall", W'(bus.o_stall), '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_data = '0;

    // Saturation of the bubble counter through repeated flushes
    bus.i_enable = 1'b1; bus.i_flush = 1'b1; bus.i_control = LOAD;
    repeat (65534) @(posedge clk);
    #1;
    check("count_fffe", W'(bus.o_bubble_count), W'(16'hFFFE));
    @(posedge clk);
    #1;
    check("count_ffff", W'(bus.o_bubble_count), W'(16'hFFFF));
    repeat (4) @(posedge clk);
    #1;
    check("count_sat", W'(bus.o_bubble_count), W'(16'hFFFF));
    check("sat_valid", W'(bus.o_valid), '0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
